// File: rtl/key_sw_debounce.sv
// Synchronises and debounces an active-low push-button and two slide switches;
// yields a stable speed code, a press-toggled direction level and a press pulse.
module key_sw_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 32'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic [1:0] sw_in,
  output logic [1:0] sw_out,
  output logic       dir,
  output logic       key_pulse
);

  localparam logic [31:0] LP_LAST = 32'(DEBOUNCE_CNT - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  logic        r_key_meta;
  logic        r_key_s;
  logic [1:0]  r_sw_meta;
  logic [1:0]  r_sw_s;

  key_state_t  r_state;
  key_state_t  w_state_nxt;
  logic [31:0] r_kcnt;
  logic [31:0] w_kcnt_nxt;
  logic        w_accept;

  logic [1:0]  r_sw_cand;
  logic [31:0] r_scnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset is in the sensitivity list so outputs
  // clear immediately, not at the next clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_meta <= 1'b1;
      r_key_s    <= 1'b1;
      r_sw_meta  <= 2'b00;
      r_sw_s     <= 2'b00;
    end else begin
      r_key_meta <= key_in;
      r_key_s    <= r_key_meta;
      r_sw_meta  <= sw_in;
      r_sw_s     <= r_sw_meta;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_kcnt_nxt  = r_kcnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_key_s) begin
          w_state_nxt = PRESS_WAIT;
          w_kcnt_nxt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (r_key_s) begin
          w_state_nxt = IDLE;
          w_kcnt_nxt  = '0;
        end else if (r_kcnt == LP_LAST) begin
          w_state_nxt = PRESSED;
          w_kcnt_nxt  = '0;
          w_accept    = 1'b1;
        end else begin
          w_kcnt_nxt  = r_kcnt + 32'd1;
        end
      end
      PRESSED: begin
        if (r_key_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_kcnt_nxt  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!r_key_s) begin
          w_state_nxt = PRESSED;
          w_kcnt_nxt  = '0;
        end else if (r_kcnt == LP_LAST) begin
          w_state_nxt = IDLE;
          w_kcnt_nxt  = '0;
        end else begin
          w_kcnt_nxt  = r_kcnt + 32'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_kcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_kcnt    <= '0;
      key_pulse <= 1'b0;
      dir       <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_kcnt    <= w_kcnt_nxt;
      key_pulse <= w_accept;
      if (w_accept) dir <= ~dir;
    end
  end

  // The candidate holds both bits, so a partial switch change restarts the count
  // and sw_out only ever moves straight to a fully settled code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_cand <= 2'b00;
      r_scnt    <= '0;
      sw_out    <= 2'b00;
    end else if (r_sw_s != r_sw_cand) begin
      r_sw_cand <= r_sw_s;
      r_scnt    <= '0;
    end else if (r_sw_cand != sw_out) begin
      if (r_scnt == LP_LAST) sw_out <= r_sw_cand;
      else                   r_scnt <= r_scnt + 32'd1;
    end else begin
      r_scnt <= '0;
    end
  end

endmodule
